// File: rtl/itlb.sv
// Fully-associative instruction TLB with single-outstanding L2 refill.
// Bare and hit lookups answer one cycle later; misses refill over an L2 req/resp channel.
module itlb #(
  parameter int ITLB_ENTRIES = 8,
  parameter int VPN_WIDTH    = 20,
  parameter int ASID_WIDTH   = 9,
  parameter int PPN_WIDTH    = 22
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  itlb_req_valid,
  input  logic                  itlb_req_virtual_mode,
  input  logic [VPN_WIDTH-1:0]  itlb_req_vpn,
  input  logic [ASID_WIDTH-1:0] itlb_req_ASID,
  output logic                  itlb_resp_valid,
  output logic [PPN_WIDTH-1:0]  itlb_resp_ppn,
  output logic                  itlb_resp_page_fault,
  output logic                  itlb_resp_access_fault,
  output logic                  l2_req_valid,
  output logic [VPN_WIDTH-1:0]  l2_req_vpn,
  output logic [ASID_WIDTH-1:0] l2_req_ASID,
  input  logic                  l2_req_ready,
  input  logic                  l2_resp_valid,
  input  logic [PPN_WIDTH-1:0]  l2_resp_ppn,
  input  logic                  l2_resp_page_fault,
  input  logic                  l2_resp_access_fault,
  input  logic                  sfence_valid
);

  localparam int PTR_W = $clog2(ITLB_ENTRIES);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e                  state_q;
  logic                    drop_q;
  logic                    l2_req_valid_q;
  logic [VPN_WIDTH-1:0]    miss_vpn_q;
  logic [ASID_WIDTH-1:0]   miss_asid_q;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [ITLB_ENTRIES-1:0] valid_q;
  logic [VPN_WIDTH-1:0]    vpn_q  [ITLB_ENTRIES];
  logic [ASID_WIDTH-1:0]   asid_q [ITLB_ENTRIES];
  logic [PPN_WIDTH-1:0]    ppn_q  [ITLB_ENTRIES];

  logic                    resp_valid_q, resp_pf_q, resp_af_q;
  logic [PPN_WIDTH-1:0]    resp_ppn_q;
  logic                    resp_valid_d, resp_pf_d, resp_af_d;
  logic [PPN_WIDTH-1:0]    resp_ppn_d;

  logic [ITLB_ENTRIES-1:0] hit_vec;
  logic                    hit;
  logic [PPN_WIDTH-1:0]    hit_ppn;
  logic [PTR_W-1:0]        victim;
  logic                    victim_is_rr;
  logic                    req_translate;
  logic                    resp_accept;
  logic                    fill_en;
  logic                    forward;

  assign req_translate = itlb_req_valid && itlb_req_virtual_mode;

  generate
    for (genvar gi = 0; gi < ITLB_ENTRIES; gi++) begin : g_match
      assign hit_vec[gi] = valid_q[gi] && (vpn_q[gi] == itlb_req_vpn)
                           && (asid_q[gi] == itlb_req_ASID);
    end
  endgenerate

  assign hit = |hit_vec;

  always_comb begin
    hit_ppn = '0;
    for (int i = 0; i < ITLB_ENTRIES; i++) begin
      if (hit_vec[i]) hit_ppn = hit_ppn | ppn_q[i];
    end
  end

  // Lowest invalid slot wins; round-robin only once the table is full.
  always_comb begin
    victim       = rr_ptr_q;
    victim_is_rr = 1'b1;
    for (int i = ITLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim       = PTR_W'(i);
        victim_is_rr = 1'b0;
      end
    end
  end

  // A same-cycle sfence kills the returning refill just like a latched drop.
  assign resp_accept = (state_q == ST_WAIT) && l2_resp_valid && !drop_q && !sfence_valid;
  assign fill_en     = resp_accept && !l2_resp_page_fault && !l2_resp_access_fault;
  assign forward     = resp_accept && req_translate
                       && (itlb_req_vpn == miss_vpn_q) && (itlb_req_ASID == miss_asid_q);

  always_comb begin
    resp_valid_d = 1'b0;
    resp_ppn_d   = '0;
    resp_pf_d    = 1'b0;
    resp_af_d    = 1'b0;
    if (itlb_req_valid) begin
      if (!itlb_req_virtual_mode) begin
        resp_valid_d = 1'b1;
        resp_ppn_d   = PPN_WIDTH'(itlb_req_vpn);
      end else if (forward) begin
        resp_valid_d = 1'b1;
        resp_ppn_d   = l2_resp_ppn;
        resp_pf_d    = l2_resp_page_fault;
        resp_af_d    = l2_resp_access_fault;
      end else if (!sfence_valid && hit) begin
        resp_valid_d = 1'b1;
        resp_ppn_d   = hit_ppn;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resp_valid_q <= 1'b0;
      resp_ppn_q   <= '0;
      resp_pf_q    <= 1'b0;
      resp_af_q    <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_ppn_q   <= resp_ppn_d;
      resp_pf_q    <= resp_pf_d;
      resp_af_q    <= resp_af_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_IDLE;
      drop_q         <= 1'b0;
      l2_req_valid_q <= 1'b0;
      miss_vpn_q     <= '0;
      miss_asid_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_translate && !hit && !sfence_valid) begin
            miss_vpn_q     <= itlb_req_vpn;
            miss_asid_q    <= itlb_req_ASID;
            l2_req_valid_q <= 1'b1;
            state_q        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (l2_req_ready) begin
            l2_req_valid_q <= 1'b0;
            drop_q         <= sfence_valid;
            state_q        <= ST_WAIT;
          end else if (sfence_valid) begin
            l2_req_valid_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (l2_resp_valid) begin
            drop_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (sfence_valid) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          l2_req_valid_q <= 1'b0;
          drop_q         <= 1'b0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  // rr_ptr survives sfence so replacement order keeps rotating.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
    end else if (sfence_valid) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[victim] <= 1'b1;
      if (victim_is_rr) rr_ptr_q <= rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_en) begin
      vpn_q[victim]  <= miss_vpn_q;
      asid_q[victim] <= miss_asid_q;
      ppn_q[victim]  <= l2_resp_ppn;
    end
  end

  assign itlb_resp_valid        = resp_valid_q;
  assign itlb_resp_ppn          = resp_ppn_q;
  assign itlb_resp_page_fault   = resp_pf_q;
  assign itlb_resp_access_fault = resp_af_q;
  assign l2_req_valid           = l2_req_valid_q;
  assign l2_req_vpn             = miss_vpn_q;
  assign l2_req_ASID            = miss_asid_q;

endmodule

// File: tb/tb_itlb.sv
// Directed testbench for itlb: bare, miss/fill, faults, replacement, sfence, async reset.
module tb_itlb;

  logic        CLK, nRST;
  logic        itlb_req_valid, itlb_req_virtual_mode;
  logic [19:0] itlb_req_vpn;
  logic [8:0]  itlb_req_ASID;
  logic        itlb_resp_valid;
  logic [21:0] itlb_resp_ppn;
  logic        itlb_resp_page_fault, itlb_resp_access_fault;
  logic        l2_req_valid;
  logic [19:0] l2_req_vpn;
  logic [8:0]  l2_req_ASID;
  logic        l2_req_ready, l2_resp_valid;
  logic [21:0] l2_resp_ppn;
  logic        l2_resp_page_fault, l2_resp_access_fault;
  logic        sfence_valid;

  int n_checks = 0;
  int n_fail   = 0;

  itlb dut (
    .CLK(CLK), .nRST(nRST),
    .itlb_req_valid(itlb_req_valid), .itlb_req_virtual_mode(itlb_req_virtual_mode),
    .itlb_req_vpn(itlb_req_vpn), .itlb_req_ASID(itlb_req_ASID),
    .itlb_resp_valid(itlb_resp_valid), .itlb_resp_ppn(itlb_resp_ppn),
    .itlb_resp_page_fault(itlb_resp_page_fault),
    .itlb_resp_access_fault(itlb_resp_access_fault),
    .l2_req_valid(l2_req_valid), .l2_req_vpn(l2_req_vpn), .l2_req_ASID(l2_req_ASID),
    .l2_req_ready(l2_req_ready), .l2_resp_valid(l2_resp_valid),
    .l2_resp_ppn(l2_resp_ppn), .l2_resp_page_fault(l2_resp_page_fault),
    .l2_resp_access_fault(l2_resp_access_fault), .sfence_valid(sfence_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic vm, input logic [19:0] vpn,
                           input logic [8:0] asid);
    itlb_req_valid        = v;
    itlb_req_virtual_mode = vm;
    itlb_req_vpn          = vpn;
    itlb_req_ASID         = asid;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive_req(0, 0, 20'h0, 9'h0);
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_ppn = '0;
    l2_resp_page_fault = 0; l2_resp_access_fault = 0; sfence_valid = 0;
    tick(); tick();
    n_checks++;
    if ({itlb_resp_valid, itlb_resp_ppn, itlb_resp_page_fault, itlb_resp_access_fault} !== 25'h0) begin
      n_fail++; $display("FAIL reset_resp: got %b_%h required 0", itlb_resp_valid, itlb_resp_ppn);
    end
    n_checks++;
    if (l2_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_l2_req: got %b required 0", l2_req_valid);
    end
    nRST = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_bare();
    drive_req(1, 0, 20'h12345, 9'h0);
    tick();
    drive_req(0, 0, 20'h0, 9'h0);
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h012345) begin
      n_fail++; $display("FAIL bare_resp: got %b %h required 1 012345", itlb_resp_valid, itlb_resp_ppn);
    end
    n_checks++;
    if (itlb_resp_page_fault !== 1'b0 || itlb_resp_access_fault !== 1'b0 || l2_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bare_side: pf=%b af=%b l2=%b required 0 0 0",
                         itlb_resp_page_fault, itlb_resp_access_fault, l2_req_valid);
    end
    tick();
    $display("bare vpn 12345 done");
  endtask

  task automatic test_miss_fill();
    drive_req(1, 1, 20'h00ABC, 9'd5);
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b1 || l2_req_vpn !== 20'h00ABC || l2_req_ASID !== 9'd5) begin
      n_fail++; $display("FAIL miss_l2_req: resp=%b l2=%b vpn=%h asid=%0d required 0 1 00abc 5",
                         itlb_resp_valid, l2_req_valid, l2_req_vpn, l2_req_ASID);
    end
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    n_checks++;
    if (l2_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_l2_req_low: got %b required 0", l2_req_valid);
    end
    tick(); tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_no_resp: got %b required 0", itlb_resp_valid);
    end
    l2_resp_valid = 1; l2_resp_ppn = 22'h3FFFF;
    tick();
    l2_resp_valid = 0;
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h3FFFF || itlb_resp_page_fault !== 1'b0) begin
      n_fail++; $display("FAIL fill_forward: got %b %h pf=%b required 1 3ffff 0",
                         itlb_resp_valid, itlb_resp_ppn, itlb_resp_page_fault);
    end
    drive_req(0, 0, 20'h0, 9'h0); tick();
    drive_req(1, 1, 20'h00ABC, 9'd5); tick();
    drive_req(0, 0, 20'h0, 9'h0);
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h3FFFF || l2_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL refetch_hit: got %b %h l2=%b required 1 3ffff 0",
                         itlb_resp_valid, itlb_resp_ppn, l2_req_valid);
    end
    tick();
    $display("miss/fill vpn 00abc asid 5 done");
  endtask

  task automatic test_asid_fault();
    drive_req(1, 1, 20'h00ABC, 9'd6);
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b1 || l2_req_ASID !== 9'd6) begin
      n_fail++; $display("FAIL asid_miss: resp=%b l2=%b asid=%0d required 0 1 6",
                         itlb_resp_valid, l2_req_valid, l2_req_ASID);
    end
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    l2_resp_valid = 1; l2_resp_ppn = 22'h0; l2_resp_page_fault = 1;
    tick();
    l2_resp_valid = 0; l2_resp_page_fault = 0;
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_page_fault !== 1'b1 || itlb_resp_access_fault !== 1'b0) begin
      n_fail++; $display("FAIL page_fault_resp: got v=%b pf=%b af=%b required 1 1 0",
                         itlb_resp_valid, itlb_resp_page_fault, itlb_resp_access_fault);
    end
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL fault_not_cached: resp=%b l2=%b required 0 1", itlb_resp_valid, l2_req_valid);
    end
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    l2_resp_valid = 1; l2_resp_access_fault = 1;
    tick();
    l2_resp_valid = 0; l2_resp_access_fault = 0;
    drive_req(0, 0, 20'h0, 9'h0);
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_access_fault !== 1'b1 || itlb_resp_page_fault !== 1'b0) begin
      n_fail++; $display("FAIL access_fault_resp: got v=%b pf=%b af=%b required 1 0 1",
                         itlb_resp_valid, itlb_resp_page_fault, itlb_resp_access_fault);
    end
    tick();
    $display("asid 6 fault refills done");
  endtask

  task automatic test_replacement();
    sfence_valid = 1; tick(); sfence_valid = 0;
    for (int i = 0; i < 8; i++) begin
      drive_req(1, 1, 20'h00100 + 20'(i), 9'd1);
      tick();
      n_checks++;
      if (l2_req_valid !== 1'b1 || l2_req_vpn !== 20'h00100 + 20'(i)) begin
        n_fail++; $display("FAIL fill%0d_l2_req: l2=%b vpn=%h required 1 %h",
                           i, l2_req_valid, l2_req_vpn, 20'h00100 + 20'(i));
      end
      l2_req_ready = 1; tick(); l2_req_ready = 0;
      l2_resp_valid = 1; l2_resp_ppn = 22'h02000 + 22'(i);
      tick();
      l2_resp_valid = 0;
      drive_req(0, 0, 20'h0, 9'h0);
      n_checks++;
      if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h02000 + 22'(i)) begin
        n_fail++; $display("FAIL fill%0d_resp: got %b %h required 1 %h",
                           i, itlb_resp_valid, itlb_resp_ppn, 22'h02000 + 22'(i));
      end
    end
    drive_req(1, 1, 20'h00108, 9'd1);
    tick();
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    drive_req(1, 1, 20'h00101, 9'd1);
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h02001) begin
      n_fail++; $display("FAIL hit_under_miss: got %b %h required 1 02001", itlb_resp_valid, itlb_resp_ppn);
    end
    drive_req(1, 1, 20'h00108, 9'd1);
    l2_resp_valid = 1; l2_resp_ppn = 22'h02008;
    tick();
    l2_resp_valid = 0;
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h02008) begin
      n_fail++; $display("FAIL fill8_resp: got %b %h required 1 02008", itlb_resp_valid, itlb_resp_ppn);
    end
    for (int i = 1; i < 9; i++) begin
      drive_req(1, 1, 20'h00100 + 20'(i), 9'd1);
      tick();
      n_checks++;
      if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h02000 + 22'(i)) begin
        n_fail++; $display("FAIL survivor%0d_hit: got %b %h required 1 %h",
                           i, itlb_resp_valid, itlb_resp_ppn, 22'h02000 + 22'(i));
      end
    end
    drive_req(1, 1, 20'h00100, 9'd1);
    tick();
    drive_req(0, 0, 20'h0, 9'h0);
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b1 || l2_req_vpn !== 20'h00100) begin
      n_fail++; $display("FAIL evicted_miss: resp=%b l2=%b vpn=%h required 0 1 00100",
                         itlb_resp_valid, l2_req_valid, l2_req_vpn);
    end
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    l2_resp_valid = 1; l2_resp_page_fault = 1;
    tick();
    l2_resp_valid = 0; l2_resp_page_fault = 0;
    $display("replacement of 9 vpns done");
  endtask

  task automatic test_sfence();
    drive_req(1, 1, 20'h00100, 9'd1);
    tick();
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    drive_req(1, 1, 20'h00102, 9'd1);
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h02002) begin
      n_fail++; $display("FAIL pre_sfence_hit: got %b %h required 1 02002", itlb_resp_valid, itlb_resp_ppn);
    end
    sfence_valid = 1; tick(); sfence_valid = 0;
    n_checks++;
    if (itlb_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL sfence_cycle_lookup: got %b required 0", itlb_resp_valid);
    end
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_sfence_miss: got %b required 0", itlb_resp_valid);
    end
    drive_req(1, 1, 20'h00100, 9'd1);
    l2_resp_valid = 1; l2_resp_ppn = 22'h03333;
    tick();
    l2_resp_valid = 0;
    n_checks++;
    if (itlb_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL dropped_resp: got %b required 0", itlb_resp_valid);
    end
    tick();
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_no_fill: resp=%b l2=%b required 0 1", itlb_resp_valid, l2_req_valid);
    end
    drive_req(1, 0, 20'h00055, 9'd0);
    sfence_valid = 1; tick(); sfence_valid = 0;
    drive_req(0, 0, 20'h0, 9'h0);
    n_checks++;
    if (l2_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL sfence_req_abort: got %b required 0", l2_req_valid);
    end
    n_checks++;
    if (itlb_resp_valid !== 1'b1 || itlb_resp_ppn !== 22'h00055) begin
      n_fail++; $display("FAIL bare_under_sfence: got %b %h required 1 00055", itlb_resp_valid, itlb_resp_ppn);
    end
    tick();
    $display("sfence in wait and req done");
  endtask

  task automatic test_async_reset();
    drive_req(1, 1, 20'h00777, 9'd2);
    tick();
    l2_req_ready = 1; tick(); l2_req_ready = 0;
    drive_req(1, 0, 20'h00044, 9'd0);
    tick();
    drive_req(0, 0, 20'h0, 9'h0);
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if ({itlb_resp_valid, itlb_resp_ppn, itlb_resp_page_fault, itlb_resp_access_fault} !== 25'h0) begin
      n_fail++; $display("FAIL async_reset_resp: got %b %h required 0 0", itlb_resp_valid, itlb_resp_ppn);
    end
    n_checks++;
    if (l2_req_valid !== 1'b0 || l2_req_vpn !== 20'h0 || l2_req_ASID !== 9'h0) begin
      n_fail++; $display("FAIL async_reset_l2: v=%b vpn=%h asid=%h required 0 0 0",
                         l2_req_valid, l2_req_vpn, l2_req_ASID);
    end
    #1 nRST = 1'b1;
    tick();
    l2_resp_valid = 1; l2_resp_ppn = 22'h01111;
    tick();
    l2_resp_valid = 0;
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL late_resp_ignored: resp=%b l2=%b required 0 0", itlb_resp_valid, l2_req_valid);
    end
    drive_req(1, 1, 20'h00777, 9'd2);
    tick();
    drive_req(0, 0, 20'h0, 9'h0);
    n_checks++;
    if (itlb_resp_valid !== 1'b0 || l2_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_miss: resp=%b l2=%b required 0 1", itlb_resp_valid, l2_req_valid);
    end
    $display("async reset in wait done");
  endtask

  initial begin
    test_reset();
    test_bare();
    test_miss_fill();
    test_asid_fault();
    test_replacement();
    test_sfence();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
